// File: rtl/mycpu_pkg.sv
// Shared CPU definitions: exception-controller state encoding and the
// default ecode reported for interrupts.
package mycpu_pkg;

  typedef enum logic [1:0] {
    EXC_IDLE     = 2'd0,
    EXC_COMMIT   = 2'd1,
    EXC_FLUSH    = 2'd2,
    EXC_REDIRECT = 2'd3
  } exc_state_e;

  localparam logic [5:0] ECODE_INT_DEF = 6'h00;

endpackage

// File: rtl/exc_flush_cnt.sv
// Flush-length down-counter for the exception controller.
//   clk, resetn : clock, asynchronous active-low reset
//   load        : load load_val (takes priority over dec)
//   load_val    : value to load
//   dec         : decrement by one, saturating at zero
//   zero        : counter currently holds zero
module exc_flush_cnt (
  input  logic       clk,
  input  logic       resetn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/exc_ctrl.sv
// Exception / ertn commit controller.
// Accepts an interrupt, exception or ertn from WB, pulses the CSR for one
// cycle, flushes the pipeline, then hands the CSR target PC to IF.
//   clk, resetn                  : clock, asynchronous active-low reset
//   wb_valid, wb_pc              : committing instruction and its PC
//   wb_exc, wb_ecode, wb_esubcode: exception flag and codes
//   wb_ertn, int_pending         : ertn flag, pending interrupt
//   csr_exc, csr_ertn            : one-cycle CSR strobes
//   csr_ecode/esubcode/epc       : latched info, zero outside the strobe
//   csr_target_pc                : CSR-supplied redirect target
//   flush                        : pipeline flush
//   redirect_valid/pc/ready      : redirect handshake towards IF
//   busy                         : controller not idle
module exc_ctrl
  import mycpu_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [5:0]  ECODE_INT    = ECODE_INT_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_exc,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic        wb_ertn,
  input  logic        int_pending,
  output logic        csr_exc,
  output logic        csr_ertn,
  output logic [5:0]  csr_ecode,
  output logic [8:0]  csr_esubcode,
  output logic [31:0] csr_epc,
  input  logic [31:0] csr_target_pc,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  exc_state_e  state, state_nxt;
  logic        accept;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic        lat_ertn;
  logic [5:0]  lat_ecode;
  logic [8:0]  lat_esub;
  logic [31:0] lat_epc;
  logic [31:0] redirect_pc_q;

  // Counter is loaded with FLUSH_CYCLES-1 so that the FLUSH state exits on
  // the cycle the counter already reads zero, giving FLUSH_CYCLES cycles.
  exc_flush_cnt u_flush_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (4'(FLUSH_CYCLES - 1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= EXC_IDLE;
      lat_ertn      <= 1'b0;
      lat_ecode     <= '0;
      lat_esub      <= '0;
      lat_epc       <= '0;
      redirect_pc_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (int_pending) begin
          lat_ertn  <= 1'b0;
          lat_ecode <= ECODE_INT;
          lat_esub  <= '0;
          lat_epc   <= wb_pc;
        end else if (wb_exc) begin
          lat_ertn  <= 1'b0;
          lat_ecode <= wb_ecode;
          lat_esub  <= wb_esubcode;
          lat_epc   <= wb_pc;
        end else begin
          lat_ertn  <= 1'b1;
          lat_ecode <= '0;
          lat_esub  <= '0;
          lat_epc   <= '0;
        end
      end
      if (state == EXC_COMMIT) begin
        redirect_pc_q <= csr_target_pc;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    accept         = 1'b0;
    cnt_load       = 1'b0;
    cnt_dec        = 1'b0;
    csr_exc        = 1'b0;
    csr_ertn       = 1'b0;
    csr_ecode      = '0;
    csr_esubcode   = '0;
    csr_epc        = '0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    busy           = (state != EXC_IDLE);
    unique case (state)
      EXC_IDLE: begin
        accept = wb_valid && (int_pending || wb_exc || wb_ertn);
        if (accept) state_nxt = EXC_COMMIT;
      end
      EXC_COMMIT: begin
        csr_exc      = !lat_ertn;
        csr_ertn     = lat_ertn;
        csr_ecode    = lat_ecode;
        csr_esubcode = lat_esub;
        csr_epc      = lat_epc;
        flush        = 1'b1;
        cnt_load     = 1'b1;
        state_nxt    = EXC_FLUSH;
      end
      EXC_FLUSH: begin
        flush   = 1'b1;
        cnt_dec = 1'b1;
        if (cnt_zero) state_nxt = EXC_REDIRECT;
      end
      EXC_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) state_nxt = EXC_IDLE;
      end
      default: state_nxt = EXC_IDLE;
    endcase
  end

  assign redirect_pc = redirect_pc_q;

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush is held after commit (legal 1..15).
REQ-002 SHALL have parameter ECODE_INT, default 6'h00, ecode reported for interrupts.
REQ-003 SHALL have ports `clk  in  1  clock`; `resetn  in  1  reset, asynchronous, active-low`.
REQ-004 SHALL have ports `wb_valid  in  1  instruction committing in WB this cycle`; `wb_pc  in  32  its PC`.
REQ-005 SHALL have ports `wb_exc  in  1  WB instruction carries exception`; `wb_ecode  in  6  its ecode`; `wb_esubcode  in  9  its esubcode`.
REQ-006 SHALL have ports `wb_ertn  in  1  WB instruction is ertn`; `int_pending  in  1  CSR interrupt request (INT_signal)`.
REQ-007 SHALL have ports `csr_exc  out  1  EXC_signal to CSR`; `csr_ertn  out  1  ERTN_signal to CSR`; `csr_ecode  out  6`; `csr_esubcode  out  9`; `csr_epc  out  32`.
REQ-008 SHALL have ports `csr_target_pc  in  32  CSR_2_IF_pc from CSR`.
REQ-009 SHALL have ports `flush  out  1  pipeline flush`; `redirect_valid  out  1`; `redirect_pc  out  32`; `redirect_ready  in  1  IF accepts redirect`; `busy  out  1  state != IDLE`.

Function
REQ-010 SHALL implement FSM IDLE, COMMIT, FLUSH, REDIRECT.
REQ-011 In IDLE with wb_valid: priority int_pending > wb_exc > wb_ertn; winner latched, state -> COMMIT next cycle.
REQ-012 Interrupt win SHALL latch ecode=ECODE_INT, esubcode=0, epc=wb_pc; exception win SHALL latch wb_ecode/wb_esubcode/wb_pc.
REQ-013 Inputs without wb_valid, or while state != IDLE, SHALL be ignored.
REQ-014 In COMMIT, exactly one of csr_exc/csr_ertn SHALL be high for exactly one cycle, with csr_ecode/esubcode/epc driving the latched values.
REQ-015 In COMMIT, redirect_pc SHALL capture csr_target_pc at the clock edge leaving COMMIT.
REQ-016 flush SHALL be high in COMMIT and FLUSH; FLUSH SHALL last exactly FLUSH_CYCLES cycles via 4-bit down-counter, then -> REDIRECT.
REQ-017 In REDIRECT, redirect_valid SHALL be high with redirect_pc stable until redirect_ready is sampled high; then -> IDLE.
REQ-018 redirect_ready outside REDIRECT SHALL have no effect.
REQ-019 csr_ecode/esubcode/epc SHALL be 0 outside COMMIT.
REQ-020 First new acceptance after a REDIRECT handshake SHALL be possible in the cycle after it (IDLE).

Reset
REQ-021 resetn low SHALL force IDLE asynchronously, counter 0, all latches 0, every output 0 (including mid-operation); no CSR pulse SHALL be emitted after reset release.

Structure
REQ-022 State encoding and ECODE_INT default SHALL live in shared package mycpu_pkg.
REQ-023 Flush counter SHALL be a sub-module exc_flush_cnt (load, decrement, zero flag); the rest is flat.

Verification
REQ-024 wb_valid=1, wb_exc=1, ecode=6'h0B, pc=32'h1c000100 -> next cycle csr_exc=1 for 1 cycle, csr_epc=32'h1c000100; flush 3 cycles; redirect_pc=csr_target_pc.
REQ-025 wb_valid, int_pending and wb_exc all 1 in the same cycle -> csr_ecode=6'h00, esubcode=0, epc=wb_pc.
REQ-026 wb_ertn=1 with csr_target_pc=32'h1c000200 -> csr_ertn pulse, csr_exc=0, redirect_pc=32'h1c000200.
REQ-027 redirect_ready held low 5 cycles -> redirect_valid stays high, pc stable; a new wb_exc during that time is ignored.
REQ-028 resetn low during FLUSH -> all outputs 0 immediately, IDLE after release, no spurious pulse.
